fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 115 +++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Opcode fetch sequencer. It issues one memory read per fetch,
//               writes IR and PC back, and supports redirects and ack timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter int ACK_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_req,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    input  logic        pc_hold,
    input  logic [15:0] r_pc,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    output logic        wen_ir,
    output logic [7:0]  w_ir,
    output logic        wen_pc,
    output logic [15:0] w_pc,
    output logic        ir_valid,
    output logic        fetch_busy,
    output logic        err
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_REQ   = 2'd1;
    localparam logic [1:0] c_ST_WB    = 2'd2;
    localparam logic [1:0] c_ST_REDIR = 2'd3;
    localparam logic [7:0] c_TIMEOUT  = 8'(ACK_TIMEOUT);

    logic [1:0] r_state;
    logic [7:0] r_wait_cnt;
    logic [7:0] w_cnt_nxt;
    logic       w_timeout;

    // The counter holds completed ack-less REQ cycles; the current cycle is
    // included in the comparison so mem_req stays up exactly ACK_TIMEOUT cycles.
    assign w_cnt_nxt = r_wait_cnt + 8'd1;
    assign w_timeout = (w_cnt_nxt == c_TIMEOUT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_wait_cnt <= 8'd0;
            mem_req    <= 1'b0;
            mem_addr   <= 16'h0000;
            wen_ir     <= 1'b0;
            w_ir       <= 8'h00;
            wen_pc     <= 1'b0;
            w_pc       <= 16'h0000;
            ir_valid   <= 1'b0;
            fetch_busy <= 1'b0;
            err        <= 1'b0;
        end else begin
            wen_ir   <= 1'b0;
            wen_pc   <= 1'b0;
            ir_valid <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    // A redirect that coincides with a fetch is folded into it.
                    if (fetch_req) begin
                        r_state    <= c_ST_REQ;
                        r_wait_cnt <= 8'd0;
                        mem_req    <= 1'b1;
                        mem_addr   <= redirect_valid ? redirect_pc : r_pc;
                        fetch_busy <= 1'b1;
                    end else if (redirect_valid) begin
                        r_state    <= c_ST_REDIR;
                        wen_pc     <= 1'b1;
                        w_pc       <= redirect_pc;
                        fetch_busy <= 1'b1;
                    end
                end
                c_ST_REQ: begin
                    if (mem_ack) begin
                        r_state  <= c_ST_WB;
                        mem_req  <= 1'b0;
                        w_ir     <= mem_rdata;
                        wen_ir   <= 1'b1;
                        ir_valid <= 1'b1;
                        if (!pc_hold) begin
                            wen_pc <= 1'b1;
                            w_pc   <= mem_addr + 16'd1;
                        end
                    end else if (w_timeout) begin
                        r_state    <= c_ST_IDLE;
                        mem_req    <= 1'b0;
                        fetch_busy <= 1'b0;
                        err        <= 1'b1;
                    end else begin
                        r_wait_cnt <= w_cnt_nxt;
                    end
                end
                c_ST_WB, c_ST_REDIR: begin
                    r_state    <= c_ST_IDLE;
                    fetch_busy <= 1'b0;
                end
                default: begin
                    r_state    <= c_ST_IDLE;
                    mem_req    <= 1'b0;
                    fetch_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
